sync_word_qualifier: RTL and testbench
======================================

Name: sync_word_qualifier

Overview:
- Fast-domain stage directly downstream of the slow-to-fast multi-bit synchronizer and the rising-edge pulse generator.
- A multi-bit word crossing domains can be sampled mid-transition. This block accepts the word only after it has been sampled identical for STABLE consecutive cycles following a write strobe.
- Qualified words are buffered in a small show-ahead FIFO and presented to the fast-domain consumer (square renderer/game logic) via valid/ready.
- Drops and stuck-transition timeouts are flagged.

Parameters:
- M, 15, word width; matches the synchronizer width.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- STABLE, 3, consecutive identical samples required; ≥2.
- TIMEOUT, 16, max cycles spent qualifying before the word is discarded; >STABLE.

Ports:
- clk  in  1  fast clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  M  synchronized word (synchronizer output).
- strobe  in  1  single-cycle write pulse (edge-detector output).
- out_data  out  M  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid=1.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a qualified word was dropped because the FIFO was full.
- timeout_err  out  1  sticky: qualification abandoned after TIMEOUT cycles.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset: state=IDLE; cand=0; cnt=0; wait_cnt=0; rd/wr pointers=0; level=0; out_valid=0; out_data=0; overflow=0; timeout_err=0. rst overrides every other input in the same edge.
- Reset mid-qualification: the in-flight word is discarded and the FIFO is emptied.
- FSM has two states, IDLE and QUAL.
- IDLE:
  - strobe=1 → cand<=data_in, cnt<=1, wait_cnt<=1, go to QUAL.
  - Otherwise data_in is ignored.
- QUAL, evaluated each edge, first match wins:
  1. data_in==cand and cnt==STABLE-1 → push cand, go to IDLE.
  2. wait_cnt==TIMEOUT-1 → discard, timeout_err<=1, go to IDLE.
  3. strobe=1 → restart: cand<=data_in, cnt<=1, wait_cnt<=1.
  4. data_in==cand → cnt<=cnt+1, wait_cnt<=wait_cnt+1.
  5. Otherwise → cand<=data_in, cnt<=1, wait_cnt<=wait_cnt+1.
- A strobe in the same cycle as a push or timeout (rules 1 and 2) is ignored; it is not latched.
- Latency: strobe sampled at edge t with data_in stable from t → push at edge t+STABLE-1. With STABLE=3, out_valid rises after edge t+2 when the FIFO was empty.
- Push:
  - level==DEPTH (evaluated before any same-cycle pop) → word dropped and overflow<=1. This applies even if a pop occurs in the same cycle.
  - Otherwise mem[wr_ptr]<=cand, wr_ptr increments, wrapping modulo DEPTH.
- Pop: out_valid & out_ready → rd_ptr increments, wrapping.
  - out_ready with out_valid=0 has no effect.
- Output data: out_data = mem[rd_ptr], show-ahead. Its value when out_valid=0 is not checked.
- Occupancy:
  - Simultaneous accepted push and pop → level unchanged.
  - Push only → +1; pop only → −1.
  - level never exceeds DEPTH or goes below 0.
- out_valid = (level!=0), registered-equivalent (derived from registered level).
- Sticky flags clear only on rst.
- Words leave the FIFO in push order.

Test Plan:
- Reset, then strobe at cycle 10 with data_in=15'h1234 held → out_valid=1 from cycle 12, out_data=15'h1234, level=1. Pulse out_ready → level=0, out_valid=0.
- Strobe with data_in=15'h0AAA at the strobe cycle, 15'h7FFF at the next, then held → cand reloads on the change; push of 15'h7FFF occurs 2 cycles after the change; 15'h0AAA is never pushed.
- data_in toggling between 15'h0001 and 15'h0002 every cycle after a strobe, TIMEOUT=16 → no push; timeout_err=1 exactly 15 edges after the strobe edge; FSM returns to IDLE.
- 9 qualified words with out_ready=0, DEPTH=8 → level=8; 9th word dropped; overflow=1. Draining gives words 1..8 in order; overflow stays 1.
- FIFO at level=8, push and pop in the same cycle → push dropped, overflow=1, level=7. Then level=4 with push+pop in the same cycle → level stays 4.
- rst asserted 1 cycle after a strobe with 3 words buffered → next edge: level=0, out_valid=0, flags 0. A word held after rst deasserts without a new strobe is never pushed.

Source files
------------

// File: rtl/sync_word_qualifier_if.sv
// rtl/sync_word_qualifier_if.sv - word input and show-ahead output handshake bundle
interface sync_word_qualifier_if #(
    parameter int M = 15
);
    logic [M-1:0] data_in;
    logic         strobe;
    logic [M-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output data_in,
        output strobe,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  data_in,
        input  strobe,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/sync_word_qualifier.sv
// rtl/sync_word_qualifier.sv - stability qualifier for a synchronized word feeding a show-ahead FIFO
module sync_word_qualifier #(
    parameter int M       = 15,
    parameter int DEPTH   = 8,
    parameter int STABLE  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    sync_word_qualifier_if.slave     bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(STABLE + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [LW-1:0] FULL      = LW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [M-1:0]    cand, cand_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [WW-1:0]   wait_cnt, wait_nxt;
    logic            push, abandon;

    logic [M-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push_ok, pop, drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cand     <= '0;
            cnt      <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cand     <= cand_nxt;
            cnt      <= cnt_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // QUAL rules are priority ordered: a completing push or a timeout swallows a same-cycle strobe.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        wait_nxt  = wait_cnt;
        push      = 1'b0;
        abandon   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.strobe) begin
                    cand_nxt  = bus.data_in;
                    cnt_nxt   = CW'(1);
                    wait_nxt  = WW'(1);
                    state_nxt = QUAL;
                end
            end
            QUAL: begin
                if (bus.data_in == cand && cnt == CNT_LAST) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    abandon   = 1'b1;
                    state_nxt = IDLE;
                end else if (bus.strobe) begin
                    cand_nxt = bus.data_in;
                    cnt_nxt  = CW'(1);
                    wait_nxt = WW'(1);
                end else if (bus.data_in == cand) begin
                    cnt_nxt  = cnt + CW'(1);
                    wait_nxt = wait_cnt + WW'(1);
                end else begin
                    cand_nxt = bus.data_in;
                    cnt_nxt  = CW'(1);
                    wait_nxt = wait_cnt + WW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fullness is judged before any same-cycle pop, so a full FIFO drops even while draining.
    assign drop    = push && (level == FULL);
    assign push_ok = push && (level != FULL);
    assign pop     = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            if (abandon) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign bus.out_valid = (level != '0);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_sync_word_qualifier.sv
// tb/tb_sync_word_qualifier.sv - directed self-checking bench for sync_word_qualifier
module tb_sync_word_qualifier;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] level;
    logic       overflow;
    logic       timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;

    sync_word_qualifier_if #(.M(15)) bus ();

    sync_word_qualifier #(
        .M(15), .DEPTH(8), .STABLE(3), .TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .level       (level),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [14:0] w);
        bus.data_in = w;
        bus.strobe  = 1'b1;
        tick();
        bus.strobe  = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [14:0] word(input int i);
        return 15'(i * 16'h0111);
    endfunction

    initial begin
        rst           = 1'b1;
        bus.data_in   = '0;
        bus.strobe    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_level", 32'(level), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        rst = 1'b0;

        // basic qualification: out_valid appears after the third edge
        repeat (6) tick();
        bus.data_in = 15'h1234;
        bus.strobe  = 1'b1;
        tick();
        bus.strobe  = 1'b0;
        check("t1_valid_e0", 32'(bus.out_valid), 0);
        tick();
        check("t1_valid_e1", 32'(bus.out_valid), 0);
        tick();
        check("t1_valid_e2", 32'(bus.out_valid), 1);
        check("t1_data", 32'(bus.out_data), 32'h1234);
        check("t1_level", 32'(level), 1);
        pop_one();
        check("t1_level_pop", 32'(level), 0);
        check("t1_valid_pop", 32'(bus.out_valid), 0);

        // candidate reload on a mid-transition change
        bus.data_in = 15'h0AAA;
        bus.strobe  = 1'b1;
        tick();
        bus.strobe  = 1'b0;
        bus.data_in = 15'h7FFF;
        tick();
        check("t2_level_chg", 32'(level), 0);
        tick();
        check("t2_level_chg1", 32'(level), 0);
        tick();
        check("t2_level_push", 32'(level), 1);
        check("t2_data", 32'(bus.out_data), 32'h7FFF);
        pop_one();
        check("t2_only_one", 32'(level), 0);

        // toggling word never settles and is abandoned after 15 edges
        bus.data_in = 15'h0001;
        bus.strobe  = 1'b1;
        tick();
        bus.strobe  = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            bus.data_in = (k % 2 == 1) ? 15'h0002 : 15'h0001;
            tick();
        end
        check("t3_timeout_e14", 32'(timeout_err), 0);
        bus.data_in = 15'h0001;
        tick();
        check("t3_timeout_e15", 32'(timeout_err), 1);
        check("t3_no_push", 32'(level), 0);
        repeat (4) tick();
        check("t3_idle_no_push", 32'(level), 0);

        // fill beyond capacity with no consumer
        for (int i = 1; i <= 9; i++) begin
            push_word(word(i));
        end
        check("t4_level_full", 32'(level), 8);
        check("t4_overflow", 32'(overflow), 1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t4_order_%0d", i), 32'(bus.out_data), 32'(word(i)));
            pop_one();
        end
        check("t4_level_drained", 32'(level), 0);
        check("t4_overflow_sticky", 32'(overflow), 1);

        // push and pop in the same cycle, full and partially full
        do_reset();
        check("t5_overflow_cleared", 32'(overflow), 0);
        check("t5_timeout_cleared", 32'(timeout_err), 0);
        for (int i = 1; i <= 8; i++) begin
            push_word(word(i));
        end
        check("t5_level_full", 32'(level), 8);
        bus.data_in = word(10);
        bus.strobe  = 1'b1;
        tick();
        bus.strobe  = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t5_full_pushpop_level", 32'(level), 7);
        check("t5_full_pushpop_ovf", 32'(overflow), 1);
        check("t5_head_after", 32'(bus.out_data), 32'(word(2)));
        repeat (3) pop_one();
        check("t5_level4", 32'(level), 4);
        bus.data_in = word(9);
        bus.strobe  = 1'b1;
        tick();
        bus.strobe  = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t5_pushpop_level", 32'(level), 4);
        for (int i = 6; i <= 9; i++) begin
            check($sformatf("t5_order_%0d", i), 32'(bus.out_data), 32'(word(i)));
            pop_one();
        end
        check("t5_level_drained", 32'(level), 0);

        // reset in the middle of qualification with words buffered
        push_word(15'h0101);
        push_word(15'h0202);
        push_word(15'h0303);
        check("t6_level3", 32'(level), 3);
        bus.data_in = 15'h4321;
        bus.strobe  = 1'b1;
        tick();
        bus.strobe  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_level", 32'(level), 0);
        check("t6_valid", 32'(bus.out_valid), 0);
        check("t6_overflow", 32'(overflow), 0);
        check("t6_timeout", 32'(timeout_err), 0);
        repeat (5) tick();
        check("t6_no_push_after_rst", 32'(level), 0);
        check("t6_valid_after_rst", 32'(bus.out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
